// File: rtl/slot_sdram_arbiter.sv
// Slot back-end: round-robin arbitration of N cartridge channels onto one SDRAM byte port,
// plus the MSX sub-slot register (0xFFFF) and sub-slot select decode for one expanded slot.
module slot_sdram_arbiter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned EXP_SLOT = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [15:0]              addr,
  input  logic                     wr_n,
  input  logic                     rd_n,
  input  logic [7:0]               d_from_cpu,
  input  logic [3:0]               SLTSL_n,
  output logic [7:0]               ssl_d,
  output logic                     ssl_oe,
  output logic [3:0]               sub_sltsl_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*8-1:0]      ch_din,
  output logic [7:0]               ch_dout,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [7:0]               sdram_din,
  output logic                     sdram_rd,
  output logic                     sdram_we,
  input  logic                     sdram_ready,
  input  logic [7:0]               sdram_dout,
  output logic                     timeout_err
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   sdram_addr_q;
  logic [7:0]          sdram_din_q;
  logic                sdram_rd_q, sdram_we_q;
  logic [NUM_CH-1:0]   ch_ready_q;
  logic [7:0]          ch_dout_q;
  logic                timeout_err_q;
  logic [7:0]          ssl_reg_q;
  logic                wr_n_q;

  logic [ADDR_W-1:0]   ch_addr_a [NUM_CH];
  logic [7:0]          ch_din_a  [NUM_CH];

  logic                gnt_vld_c;
  logic [IDX_W-1:0]    gnt_idx_c;
  int unsigned         cand_c;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_addr_a[g] = ch_addr[g*ADDR_W +: ADDR_W];
    assign ch_din_a[g]  = ch_din[g*8 +: 8];
  end

  // First requester at or after the rotating pointer, wrapping at NUM_CH-1.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand_c = 32'(ptr_q) + i;
      if (cand_c >= NUM_CH) cand_c = cand_c - NUM_CH;
      if (!gnt_vld_c && ch_req[IDX_W'(cand_c)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = IDX_W'(cand_c);
      end
    end
  end

  assign ptr_d = (gnt_q == IDX_W'(NUM_CH - 1)) ? '0 : gnt_q + IDX_W'(1);
  assign cnt_d = cnt_q + CNT_W'(1);

  // Transaction FSM; command and completion pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      sdram_addr_q  <= '0;
      sdram_din_q   <= '0;
      sdram_rd_q    <= 1'b0;
      sdram_we_q    <= 1'b0;
      ch_ready_q    <= '0;
      ch_dout_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      sdram_rd_q <= 1'b0;
      sdram_we_q <= 1'b0;
      ch_ready_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_c) begin
            gnt_q        <= gnt_idx_c;
            we_q         <= ch_we[gnt_idx_c];
            sdram_addr_q <= ch_addr_a[gnt_idx_c];
            sdram_din_q  <= ch_din_a[gnt_idx_c];
            sdram_rd_q   <= ~ch_we[gnt_idx_c];
            sdram_we_q   <= ch_we[gnt_idx_c];
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the timeout cycle takes priority.
          if (sdram_ready) begin
            ch_dout_q  <= we_q ? 8'hFF : sdram_dout;
            ch_ready_q <= (NUM_CH)'(1) << gnt_q;
            state_q    <= S_DONE;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            ch_dout_q     <= 8'hFF;
            ch_ready_q    <= (NUM_CH)'(1) << gnt_q;
            timeout_err_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sdram_addr  = sdram_addr_q;
  assign sdram_din   = sdram_din_q;
  assign sdram_rd    = sdram_rd_q;
  assign sdram_we    = sdram_we_q;
  assign ch_ready    = ch_ready_q;
  assign ch_dout     = ch_dout_q;
  assign timeout_err = timeout_err_q;

  logic       slot_sel_c, addr_ffff_c, ssl_wr_c;
  logic [1:0] sub_idx_c;

  assign slot_sel_c  = ~SLTSL_n[EXP_SLOT];
  assign addr_ffff_c = (addr == 16'hFFFF);
  // wr_n is sampled on clk_en so a long strobe produces a single falling edge.
  assign ssl_wr_c    = clk_en & wr_n_q & ~wr_n & slot_sel_c & addr_ffff_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_n_q    <= 1'b1;
      ssl_reg_q <= '0;
    end else begin
      if (clk_en) wr_n_q <= wr_n;
      if (ssl_wr_c) ssl_reg_q <= d_from_cpu;
    end
  end

  assign ssl_d     = ~ssl_reg_q;
  assign ssl_oe    = slot_sel_c & addr_ffff_c & ~rd_n;
  assign sub_idx_c = ssl_reg_q[{addr[15:14], 1'b0} +: 2];

  always_comb begin
    sub_sltsl_n = 4'hF;
    if (slot_sel_c && !addr_ffff_c) sub_sltsl_n[sub_idx_c] = 1'b0;
  end

endmodule

// File: tb/tb_slot_sdram_arbiter.sv
// Directed bench for slot_sdram_arbiter: expected SDRAM commands and channel completions are
// queued by the stimulus and checked by independent monitors.
module tb_slot_sdram_arbiter;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned TIMEOUT = 255;

  logic                     clk, reset, clk_en;
  logic [15:0]              addr;
  logic                     wr_n, rd_n;
  logic [7:0]               d_from_cpu;
  logic [3:0]               SLTSL_n;
  logic [7:0]               ssl_d;
  logic                     ssl_oe;
  logic [3:0]               sub_sltsl_n;
  logic [NUM_CH-1:0]        ch_req, ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*8-1:0]      ch_din;
  logic [7:0]               ch_dout;
  logic [NUM_CH-1:0]        ch_ready;
  logic [ADDR_W-1:0]        sdram_addr;
  logic [7:0]               sdram_din;
  logic                     sdram_rd, sdram_we, sdram_ready;
  logic [7:0]               sdram_dout;
  logic                     timeout_err;

  logic [ADDR_W-1:0] a_arr [NUM_CH];
  logic [7:0]        d_arr [NUM_CH];
  assign ch_addr = {a_arr[1], a_arr[0]};
  assign ch_din  = {d_arr[1], d_arr[0]};

  slot_sdram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .EXP_SLOT(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr), .wr_n(wr_n), .rd_n(rd_n),
    .d_from_cpu(d_from_cpu), .SLTSL_n(SLTSL_n), .ssl_d(ssl_d), .ssl_oe(ssl_oe),
    .sub_sltsl_n(sub_sltsl_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_din(ch_din), .ch_dout(ch_dout), .ch_ready(ch_ready), .sdram_addr(sdram_addr),
    .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_ready(sdram_ready), .sdram_dout(sdram_dout), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic              rd;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } cmd_t;

  typedef struct packed {
    logic [NUM_CH-1:0] rdy;
    logic [7:0]        dout;
    logic [31:0]       lat;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cmd_cyc = 0;
  int   rd_cnt = 0;
  logic resp_en = 1'b1;
  int   resp_dly = 1;
  logic [7:0] resp_data = 8'h00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1 clk_en = ~clk_en;
    end
  end

  // SDRAM model: answers each command after resp_dly cycles while enabled.
  initial begin
    sdram_ready = 1'b0;
    sdram_dout  = 8'h00;
    forever begin
      @(negedge clk);
      if ((sdram_rd || sdram_we) && resp_en) begin
        repeat (resp_dly) @(posedge clk);
        #1 sdram_ready = 1'b1;
        sdram_dout = resp_data;
        @(posedge clk);
        #1 sdram_ready = 1'b0;
        sdram_dout = 8'h00;
      end
    end
  end

  // Command monitor.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (sdram_rd || sdram_we) begin
        last_cmd_cyc = cyc;
        if (sdram_rd) rd_cnt++;
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", 32'({sdram_rd, sdram_we}), 32'(0));
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_rd", 32'(sdram_rd), 32'(c.rd));
          chk("cmd_we", 32'(sdram_we), 32'(c.we));
          chk("cmd_addr", 32'(sdram_addr), 32'(c.a));
          chk("cmd_din", 32'(sdram_din), 32'(c.d));
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (ch_ready != '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_ready", 32'(ch_ready), 32'(0));
        end else begin
          r = rsp_q.pop_front();
          chk("ready_vec", 32'(ch_ready), 32'(r.rdy));
          chk("ch_dout", 32'(ch_dout), 32'(r.dout));
          if (r.lat != 0) chk("latency", 32'(cyc - last_cmd_cyc), r.lat);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic exp_txn(input bit [0:0] ch, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d, input logic [7:0] dout, input int lat);
    cmd_q.push_back('{rd: ~we, we: we, a: a, d: d});
    rsp_q.push_back('{rdy: NUM_CH'(1) << ch, dout: dout, lat: 32'(lat)});
  endtask

  task automatic do_req(input bit [0:0] ch, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] d);
    bit got = 1'b0;
    ch_we[ch] = we;
    a_arr[ch] = a;
    d_arr[ch] = d;
    ch_req[ch] = 1'b1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (ch_ready[ch]) got = 1'b1;
    end
    ch_req[ch] = 1'b0;
    if (!got) chk("req_wait_expired", 32'(0), 32'(1));
  endtask

  initial begin
    logic [15:0] ta [5];
    logic [3:0]  te [5];
    bit          got;
    ta = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h7FFF};
    te = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1101};

    reset = 1'b1; addr = 16'h0000; wr_n = 1'b1; rd_n = 1'b1; d_from_cpu = 8'h00;
    SLTSL_n = 4'hF; ch_req = '0; ch_we = '0;
    a_arr[0] = '0; a_arr[1] = '0; d_arr[0] = '0; d_arr[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_ready", 32'(ch_ready), 32'(0));
    chk("rst_sdram_rd", 32'(sdram_rd), 32'(0));
    chk("rst_sdram_we", 32'(sdram_we), 32'(0));
    chk("rst_sdram_addr", 32'(sdram_addr), 32'(0));
    chk("rst_ssl_d", 32'(ssl_d), 32'(8'hFF));
    chk("rst_sub_sltsl_n", 32'(sub_sltsl_n), 32'(4'hF));
    chk("rst_ssl_oe", 32'(ssl_oe), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    chk("rst_ch_dout", 32'(ch_dout), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Single read, SDRAM answers 3 cycles after the command.
    resp_dly = 3; resp_data = 8'hA5; rd_cnt = 0;
    exp_txn(1'b0, 1'b0, 25'h0001234, 8'h00, 8'hA5, 4);
    do_req(1'b0, 1'b0, 25'h0001234, 8'h00);
    repeat (3) @(negedge clk);
    chk("rd_pulse_count", 32'(rd_cnt), 32'(1));

    // Round robin from reset, then after a lone ch0 access ch1 is ahead.
    do_reset();
    resp_dly = 1; resp_data = 8'h5A;
    exp_txn(1'b0, 1'b0, 25'h0000100, 8'h00, 8'h5A, 2);
    exp_txn(1'b1, 1'b1, 25'h0000200, 8'hC3, 8'hFF, 2);
    fork
      do_req(1'b0, 1'b0, 25'h0000100, 8'h00);
      do_req(1'b1, 1'b1, 25'h0000200, 8'hC3);
    join
    exp_txn(1'b0, 1'b0, 25'h0000300, 8'h00, 8'h5A, 2);
    do_req(1'b0, 1'b0, 25'h0000300, 8'h00);
    exp_txn(1'b1, 1'b0, 25'h0000400, 8'h00, 8'h5A, 2);
    exp_txn(1'b0, 1'b1, 25'h0000500, 8'h77, 8'hFF, 2);
    fork
      do_req(1'b0, 1'b1, 25'h0000500, 8'h77);
      do_req(1'b1, 1'b0, 25'h0000400, 8'h00);
    join

    // Ready on the very cycle the timeout would fire: data kept, no error.
    resp_dly = 255; resp_data = 8'h3C;
    exp_txn(1'b0, 1'b0, 25'h1FFFFFF, 8'h00, 8'h3C, 256);
    do_req(1'b0, 1'b0, 25'h1FFFFFF, 8'h00);
    @(negedge clk);
    chk("no_err_on_tie", 32'(timeout_err), 32'(0));

    // No SDRAM answer: forced completion after TIMEOUT wait cycles.
    resp_en = 1'b0;
    exp_txn(1'b1, 1'b1, 25'h00ABCDE, 8'h99, 8'hFF, 256);
    do_req(1'b1, 1'b1, 25'h00ABCDE, 8'h99);
    @(negedge clk);
    chk("timeout_err_set", 32'(timeout_err), 32'(1));
    resp_en = 1'b1; resp_dly = 1; resp_data = 8'h42;
    exp_txn(1'b0, 1'b0, 25'h0000010, 8'h00, 8'h42, 2);
    do_req(1'b0, 1'b0, 25'h0000010, 8'h00);
    @(negedge clk);
    chk("timeout_err_sticky", 32'(timeout_err), 32'(1));
    do_reset();
    chk("timeout_err_cleared", 32'(timeout_err), 32'(0));

    // Sub-slot register: one long strobe, data changed mid-strobe must not land.
    SLTSL_n = 4'b0111; addr = 16'hFFFF; d_from_cpu = 8'hE4;
    @(posedge clk); #1 wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 d_from_cpu = 8'h00;
    repeat (8) @(posedge clk);
    #1 wr_n = 1'b1;
    @(posedge clk); #1;
    chk("ssl_d_after_write", 32'(ssl_d), 32'(8'h1B));
    chk("ssl_oe_idle", 32'(ssl_oe), 32'(0));
    rd_n = 1'b0; #1;
    chk("ssl_oe_read", 32'(ssl_oe), 32'(1));
    chk("sub_sltsl_ffff", 32'(sub_sltsl_n), 32'(4'hF));
    rd_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = ta[i]; #1;
      chk("sub_sltsl_decode", 32'(sub_sltsl_n), 32'(te[i]));
    end
    SLTSL_n = 4'b1011; addr = 16'h4000; #1;
    chk("sub_sltsl_other_slot", 32'(sub_sltsl_n), 32'(4'hF));
    SLTSL_n = 4'b1110; addr = 16'hFFFF; d_from_cpu = 8'h00; rd_n = 1'b0; #1;
    chk("ssl_oe_other_slot", 32'(ssl_oe), 32'(0));
    rd_n = 1'b1;
    @(posedge clk); #1 wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 wr_n = 1'b1;
    @(posedge clk); #1;
    chk("ssl_write_other_slot", 32'(ssl_d), 32'(8'h1B));
    SLTSL_n = 4'hF; addr = 16'h0000;

    // Reset while waiting on SDRAM abandons the transaction.
    resp_en = 1'b0;
    cmd_q.push_back('{rd: 1'b1, we: 1'b0, a: 25'h0055AA0, d: 8'h00});
    ch_we[0] = 1'b0; a_arr[0] = 25'h0055AA0; d_arr[0] = 8'h00; ch_req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sdram_rd) got = 1'b1;
    end
    chk("rd_before_reset", 32'(got), 32'(1));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sdram_rd", 32'(sdram_rd), 32'(0));
    chk("mid_rst_sdram_addr", 32'(sdram_addr), 32'(0));
    chk("mid_rst_ch_ready", 32'(ch_ready), 32'(0));
    chk("mid_rst_ssl_d", 32'(ssl_d), 32'(8'hFF));
    ch_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    resp_en = 1'b1;

    chk("cmd_queue_drained", 32'(cmd_q.size()), 32'(0));
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
